// File: rtl/bch_decode_ctrl.sv
// bch_decode_ctrl: sequencer for a BCH decoder.
// It loads one codeword into the syndrome engine, checks the syndromes, and runs
// Berlekamp-Massey and then the Chien search. It reports clean, corrected or
// uncorrectable.
// Optional watchdog on the BM and CHIEN waits: define BCH_DECODE_CTRL_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start; start clears the syndrome engine
// LOAD    | accepting codeword beats (cw_ready high)
// SYN_CHK | one cycle: syndromes all zero -> clean, else launch BM
// BM      | waiting for bm_done; degree 0 or above t is uncorrectable
// CHIEN   | waiting for chien_done; root count must match degree
// DONE    | one-cycle dec_done with status/nerr already latched
module bch_decode_ctrl #(
    parameter int BEATS_P      = 64,
    parameter int BCH_T_P      = 8,
    parameter int TMO_CYCLES_P = 4096,
    localparam int DEG_W       = $clog2(BCH_T_P + 1) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cw_valid,
    output logic             cw_ready,
    output logic             syn_clr,
    output logic             syn_en,
    input  logic             syn_zero,
    output logic             bm_start,
    input  logic             bm_done,
    input  logic [DEG_W-1:0] bm_deg,
    output logic             chien_start,
    input  logic             chien_done,
    input  logic [DEG_W-1:0] chien_roots,
    output logic             dec_done,
    output logic [1:0]       dec_status,
    output logic [DEG_W-1:0] dec_nerr,
    output logic             busy
);

    localparam int CNT_W = (BEATS_P > 1) ? $clog2(BEATS_P) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_P - 1);
    localparam logic [DEG_W-1:0] T_MAX     = DEG_W'(BCH_T_P);

    localparam logic [1:0] ST_CLEAN  = 2'd0;
    localparam logic [1:0] ST_CORR   = 2'd1;
    localparam logic [1:0] ST_UNCORR = 2'd2;
    localparam logic [1:0] ST_TMO    = 2'd3;

    if (BEATS_P < 2 || BCH_T_P < 1 || TMO_CYCLES_P < 1) begin : g_param_chk
        $error("bch_decode_ctrl: BEATS_P >= 2, BCH_T_P >= 1, TMO_CYCLES_P >= 1 required");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SYN_CHK = 3'd2,
        BM      = 3'd3,
        CHIEN   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEG_W-1:0] deg_q, deg_d;
    logic [1:0]       status_q, status_d;
    logic [DEG_W-1:0] nerr_q, nerr_d;
    logic             tmo;

`ifdef BCH_DECODE_CTRL_TIMEOUT_EN
    localparam int TMO_W = (TMO_CYCLES_P > 1) ? $clog2(TMO_CYCLES_P) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYCLES_P - 1);

    logic [TMO_W-1:0] wdog_q;
    logic             in_wait;

    assign in_wait = (state_q == BM) || (state_q == CHIEN);

    // Watchdog down-counter: reload on every state change, count while waiting on an engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (state_d != state_q) begin
            wdog_q <= TMO_LOAD;
        end else if (in_wait && (wdog_q != '0)) begin
            wdog_q <= wdog_q - 1'b1;
        end
    end

    assign tmo = in_wait && (wdog_q == '0);
`else
    assign tmo = 1'b0;
`endif

    // Next-state, datapath updates and strobes; status/nerr are latched on the way into DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        deg_d       = deg_q;
        status_d    = status_q;
        nerr_d      = nerr_q;
        cw_ready    = 1'b0;
        syn_clr     = 1'b0;
        bm_start    = 1'b0;
        chien_start = 1'b0;
        dec_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    syn_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cw_ready = 1'b1;
                if (cw_valid) begin
                    // hold on the last beat so the counter never wraps inside a codeword
                    if (cnt_q == LAST_BEAT) begin
                        state_d = SYN_CHK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SYN_CHK: begin
                if (syn_zero) begin
                    status_d = ST_CLEAN;
                    nerr_d   = '0;
                    state_d  = DONE;
                end else begin
                    bm_start = 1'b1;
                    state_d  = BM;
                end
            end
            BM: begin
                if (bm_done) begin
                    deg_d = bm_deg;
                    if ((bm_deg == '0) || (bm_deg > T_MAX)) begin
                        status_d = ST_UNCORR;
                        nerr_d   = '0;
                        state_d  = DONE;
                    end else begin
                        chien_start = 1'b1;
                        state_d     = CHIEN;
                    end
                end else if (tmo) begin
                    status_d = ST_TMO;
                    nerr_d   = '0;
                    state_d  = DONE;
                end
            end
            CHIEN: begin
                if (chien_done) begin
                    if (chien_roots == deg_q) begin
                        status_d = ST_CORR;
                        nerr_d   = deg_q;
                    end else begin
                        status_d = ST_UNCORR;
                        nerr_d   = '0;
                    end
                    state_d = DONE;
                end else if (tmo) begin
                    status_d = ST_TMO;
                    nerr_d   = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                dec_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            deg_q    <= '0;
            status_q <= ST_CLEAN;
            nerr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            deg_q    <= deg_d;
            status_q <= status_d;
            nerr_q   <= nerr_d;
        end
    end

    assign syn_en     = cw_valid && cw_ready;
    assign busy       = (state_q != IDLE);
    assign dec_status = status_q;
    assign dec_nerr   = nerr_q;

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// tb_bch_decode_ctrl: randomized self-checking bench for bch_decode_ctrl.
// Cycle 1 is the cycle in which start is high. A clean codeword at full rate
// must show dec_done in cycle BEATS+3.
module tb_bch_decode_ctrl;

    localparam int BEATS = 64;
    localparam int T     = 8;
    localparam int TMO   = 4096;
    localparam int DEG_W = $clog2(T + 1) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cw_valid = 1'b0;
    logic             syn_zero = 1'b0;
    logic             bm_done = 1'b0;
    logic             chien_done = 1'b0;
    logic [DEG_W-1:0] bm_deg = '0;
    logic [DEG_W-1:0] chien_roots = '0;
    logic             cw_ready, syn_clr, syn_en, bm_start, chien_start, dec_done, busy;
    logic [1:0]       dec_status;
    logic [DEG_W-1:0] dec_nerr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bch_decode_ctrl #(
        .BEATS_P      (BEATS),
        .BCH_T_P      (T),
        .TMO_CYCLES_P (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cw_valid    (cw_valid),
        .cw_ready    (cw_ready),
        .syn_clr     (syn_clr),
        .syn_en      (syn_en),
        .syn_zero    (syn_zero),
        .bm_start    (bm_start),
        .bm_done     (bm_done),
        .bm_deg      (bm_deg),
        .chien_start (chien_start),
        .chien_done  (chien_done),
        .chien_roots (chien_roots),
        .dec_done    (dec_done),
        .dec_status  (dec_status),
        .dec_nerr    (dec_nerr),
        .busy        (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // One decode: bm_dly/ch_dly are engine response delays in cycles (negative = never answer).
    // With hang set, no dec_done is expected within max_cyc.
    task automatic run_cw(input string tag, input bit sz, input int deg, input int roots,
                          input int vpct, input int bm_dly, input int ch_dly,
                          input int max_cyc, input bit hang);
        int cyc, n_en, n_clr, n_bm, n_ch, n_done, last_beat, done_cyc;
        int bm_wait, ch_wait, rdy_late, st_seen, nerr_seen;
        int exp_st, exp_n, exp_bm, exp_ch, extra;
        bit noise;
        cyc = 0; n_en = 0; n_clr = 0; n_bm = 0; n_ch = 0; n_done = 0;
        last_beat = 0; done_cyc = 0; bm_wait = 0; ch_wait = 0; rdy_late = 0;
        st_seen = 0; nerr_seen = 0;

        // reference outcome from the decode rules
        if (sz) begin
            exp_st = 0; exp_n = 0; exp_bm = 0; exp_ch = 0; extra = 0;
        end else if (bm_dly < 0) begin
            exp_st = 3; exp_n = 0; exp_bm = 1; exp_ch = 0; extra = TMO;
        end else if (deg == 0 || deg > T) begin
            exp_st = 2; exp_n = 0; exp_bm = 1; exp_ch = 0; extra = bm_dly + 1;
        end else begin
            exp_bm = 1; exp_ch = 1; extra = bm_dly + 1 + ch_dly + 1;
            if (roots == deg) begin exp_st = 1; exp_n = deg; end
            else              begin exp_st = 2; exp_n = 0;   end
        end

        @(posedge clk); #1;
        syn_zero    = sz;
        bm_deg      = DEG_W'(deg);
        chien_roots = DEG_W'(roots);
        start       = 1'b1;
        cw_valid    = roll(vpct);
        cyc         = 1;
        while (n_done == 0 && cyc < max_cyc) begin
            @(negedge clk);
            if (n_en >= BEATS && cw_ready) rdy_late++;
            if (syn_en) begin
                n_en++;
                if (n_en == BEATS) last_beat = cyc;
            end
            if (syn_clr) n_clr++;
            if (bm_start) begin
                n_bm++;
                if (bm_dly >= 0) bm_wait = bm_dly + 1;
            end
            if (chien_start) begin
                n_ch++;
                if (ch_dly >= 0) ch_wait = ch_dly + 1;
            end
            if (dec_done) begin
                n_done++;
                done_cyc  = cyc;
                st_seen   = int'(dec_status);
                nerr_seen = int'(dec_nerr);
            end
            @(posedge clk); #1;
            cyc++;
            // stray start/done pulses while beats are still loading must be ignored
            noise      = (n_en < BEATS);
            start      = noise && roll(10);
            cw_valid   = roll(vpct);
            bm_done    = noise && roll(10);
            chien_done = noise && roll(10);
            if (bm_wait > 0) begin
                bm_wait--;
                if (bm_wait == 0) bm_done = 1'b1;
            end
            if (ch_wait > 0) begin
                ch_wait--;
                if (ch_wait == 0) chien_done = 1'b1;
            end
        end
        start = 1'b0; cw_valid = 1'b0; bm_done = 1'b0; chien_done = 1'b0;

        chk({tag, " beats"}, n_en, BEATS);
        chk({tag, " syn_clr"}, n_clr, 1);
        chk({tag, " ready_after_last"}, rdy_late, 0);
        if (vpct >= 100) chk({tag, " last_beat_cyc"}, last_beat, BEATS + 1);

        if (hang) begin
            chk({tag, " no_done"}, n_done, 0);
            @(negedge clk);
            chk({tag, " busy_held"}, int'(busy), 1);
            rst_n = 1'b0;
            #1;
            chk({tag, " busy_after_rst"}, int'(busy), 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            chk({tag, " done"}, n_done, 1);
            chk({tag, " done_cyc"}, done_cyc, last_beat + 2 + extra);
            chk({tag, " status"}, st_seen, exp_st);
            chk({tag, " nerr"}, nerr_seen, exp_n);
            chk({tag, " bm_start"}, n_bm, exp_bm);
            chk({tag, " chien_start"}, n_ch, exp_ch);
            @(negedge clk);
            chk({tag, " done_pulse_end"}, int'(dec_done), 0);
            chk({tag, " idle"}, int'(busy), 0);
            chk({tag, " status_held"}, int'(dec_status), exp_st);
            chk({tag, " nerr_held"}, int'(dec_nerr), exp_n);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " cw_ready"}, int'(cw_ready), 0);
        chk({tag, " syn_clr"}, int'(syn_clr), 0);
        chk({tag, " syn_en"}, int'(syn_en), 0);
        chk({tag, " bm_start"}, int'(bm_start), 0);
        chk({tag, " chien_start"}, int'(chien_start), 0);
        chk({tag, " dec_done"}, int'(dec_done), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " status"}, int'(dec_status), 0);
        chk({tag, " nerr"}, int'(dec_nerr), 0);
    endtask

    initial begin
        int n, nd, c, deg, roots;
        bit sz;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_cw("clean",       1'b1, 0, 0, 100, 0, 0, 400, 1'b0);
        run_cw("corr3",       1'b0, 3, 3, 100, 2, 1, 400, 1'b0);
        run_cw("deg9",        1'b0, 9, 9, 100, 1, 0, 400, 1'b0);
        run_cw("deg4_roots2", 1'b0, 4, 2, 100, 0, 3, 400, 1'b0);
        run_cw("deg0",        1'b0, 0, 0, 100, 0, 0, 400, 1'b0);
        run_cw("deg_t",       1'b0, T, T, 100, 0, 0, 400, 1'b0);
        run_cw("deg_t_miss",  1'b0, T, T - 1, 100, 0, 0, 400, 1'b0);
        run_cw("backpress",   1'b0, 5, 5, 50, 3, 2, 800, 1'b0);

        // reset in the middle of LOAD, then a fresh codeword
        @(posedge clk); #1;
        start = 1'b1; cw_valid = 1'b1; syn_zero = 1'b0;
        n = 0; nd = 0; c = 0;
        while (n < 30 && c < 200) begin
            @(negedge clk);
            if (syn_en) n++;
            if (dec_done) nd++;
            c++;
            if (n < 30) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        chk("midload beats_before_rst", n, 30);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midload_rst");
        chk("midload no_done", nd, 0);
        cw_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_cw("after_rst", 1'b0, 2, 2, 100, 1, 1, 400, 1'b0);

        for (int i = 0; i < 16; i++) begin
            sz    = roll(25);
            deg   = int'($urandom_range(12));
            roots = roll(50) ? deg : int'($urandom_range(12));
            run_cw("rand", sz, deg, roots, int'($urandom_range(100, 30)),
                   int'($urandom_range(4)), int'($urandom_range(4)), 1000, 1'b0);
        end

`ifdef BCH_DECODE_CTRL_TIMEOUT_EN
        run_cw("bm_timeout", 1'b0, 3, 3, 100, -1, 0, BEATS + TMO + 200, 1'b0);
`else
        run_cw("bm_hang", 1'b0, 3, 3, 100, -1, 0, BEATS + 600, 1'b1);
`endif
        run_cw("post", 1'b1, 0, 0, 100, 0, 0, 400, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/bch_decode_ctrl.md
BCH_DECODE_CTRL -- requirements
Module: bch_decode_ctrl

Interface
REQ-001 The block SHALL have parameter BEATS_P, default 64: data beats per codeword, minimum 2.
REQ-002 The block SHALL have parameter BCH_T_P, default 8: correctable bit errors t.
REQ-003 The block SHALL have parameter TMO_CYCLES_P, default 4096: watchdog limit per engine stage.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request decode of one codeword; sampled in IDLE only.
REQ-007 The block SHALL have port cw_valid, input, 1 bit: codeword beat valid from source.
REQ-008 The block SHALL have port cw_ready, output, 1 bit: beat accepted when cw_valid && cw_ready.
REQ-009 The block SHALL have port syn_clr, output, 1 bit: one-cycle clear pulse to the syndrome engine.
REQ-010 The block SHALL have port syn_en, output, 1 bit: syndrome accumulate enable, equal to cw_valid && cw_ready.
REQ-011 The block SHALL have port syn_zero, input, 1 bit: all syndromes zero, valid in SYN_CHK.
REQ-012 The block SHALL have port bm_start, output, 1 bit: Berlekamp-Massey start pulse.
REQ-013 The block SHALL have port bm_done, input, 1 bit: BM complete pulse.
REQ-014 The block SHALL have port bm_deg, input, $clog2(BCH_T_P+1)+1 bits: error-locator degree.
REQ-015 The block SHALL have port chien_start, output, 1 bit: Chien search start pulse.
REQ-016 The block SHALL have port chien_done, input, 1 bit: Chien complete pulse.
REQ-017 The block SHALL have port chien_roots, input, same width as bm_deg: number of roots found.
REQ-018 The block SHALL have port dec_done, output, 1 bit: one-cycle result pulse.
REQ-019 The block SHALL have port dec_status, output, 2 bits: 0 clean, 1 corrected, 2 uncorrectable, 3 timeout.
REQ-020 The block SHALL have port dec_nerr, output, same width as bm_deg: corrected bit count, held until next dec_done.
REQ-021 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-022 The state machine SHALL have the states IDLE, LOAD, SYN_CHK, BM, CHIEN and DONE.
REQ-023 In IDLE, start=1 SHALL pulse syn_clr for exactly one cycle, zero the beat counter and enter LOAD on the next edge.
REQ-024 In LOAD, cw_ready SHALL be 1; each handshake SHALL increment the beat counter; the handshake of beat BEATS_P-1 SHALL enter SYN_CHK; cw_ready SHALL be 0 outside LOAD.
REQ-025 SYN_CHK SHALL last one cycle: syn_zero=1 enters DONE with status 0 and nerr 0; otherwise it pulses bm_start and enters BM.
REQ-026 In BM, bm_done SHALL latch bm_deg; bm_deg==0 or bm_deg>BCH_T_P enters DONE with status 2; otherwise it pulses chien_start and enters CHIEN.
REQ-027 In CHIEN, chien_done with chien_roots==latched deg SHALL enter DONE with status 1 and nerr=deg; any mismatch SHALL give status 2 and nerr 0.
REQ-028 DONE SHALL pulse dec_done for one cycle with status and nerr stable, then return to IDLE; minimum start-to-dec_done latency is BEATS_P+3 cycles.
REQ-029 Start pulses, and done inputs arriving outside their own state, SHALL be ignored without error.
REQ-030 The beat counter SHALL be $clog2(BEATS_P) bits wide and SHALL never wrap within a codeword.

Reset
REQ-031 On rst_n low, the block SHALL immediately enter IDLE and drive cw_ready, syn_clr, bm_start, chien_start, dec_done and busy to 0, dec_status to 0, dec_nerr to 0, and clear the counters.
REQ-032 A reset during any state SHALL abort the decode with no dec_done pulse.

Configuration
REQ-033 With BCH_DECODE_CTRL_TIMEOUT_EN defined, a watchdog SHALL count cycles in BM and CHIEN, restart on every state entry, and, on reaching TMO_CYCLES_P, enter DONE with status 3 and nerr 0.
REQ-034 With BCH_DECODE_CTRL_TIMEOUT_EN undefined, no watchdog logic SHALL exist, status 3 SHALL never occur, and BM/CHIEN SHALL wait indefinitely.

Verification
REQ-035 Clean codeword: BEATS_P=64 beats, syn_zero=1 -> dec_done at cycle 67 after start, status 0, nerr 0.
REQ-036 Correctable case: syn_zero=0, bm_deg=3, chien_roots=3 -> status 1, nerr 3, exactly one bm_start and one chien_start pulse.
REQ-037 Uncorrectable cases: bm_deg=9 with t=8 -> status 2 with no chien_start; bm_deg=4 with chien_roots=2 -> status 2.
REQ-038 Back-pressure: cw_valid toggling 50% -> exactly 64 syn_en pulses, and cw_ready low after the last beat.
REQ-039 Reset asserted mid-LOAD at beat 30 -> all outputs 0 at once; a new start then accepts 64 fresh beats.
REQ-040 With the macro defined, bm_done withheld -> status 3 after 4096 cycles in BM; without the macro -> busy stays 1.
